mux32_1_rd: RTL and testbench

//  Read-side counterpart of the PE's 1:32 write demux. Selects one of 32 32-bit

---
 rtl/mux32_1_rd_if.sv | 22 ++
 rtl/mux32_1_rd.sv | 77 +++++++
 tb/tb_mux32_1_rd.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mux32_1_rd_if.sv
// Read request/response channel for the 32:1 register read mux.
// The master issues requests and consumes responses. The slave is the mux.
interface mux32_1_rd_if #(
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic [4:0]        req_sel;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_ready;

   modport master (
      output req_valid, req_sel, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_sel, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mux32_1_rd.sv
// Read side of the PE register file: a 32:1 word select feeding a 2-entry
// in-order response FIFO, with optional x0 hardwiring and write bypass.
module mux32_1_rd #(
   parameter int DATA_W    = 32,
   parameter bit ZERO_REG0 = 1'b1,
   parameter bit BYPASS    = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [32*DATA_W-1:0] in_flat,
   input  logic                wr_en,
   input  logic [4:0]          wr_sel,
   input  logic [DATA_W-1:0]   wr_data,
   mux32_1_rd_if.slave         rd
);

   logic [DATA_W-1:0] entry_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q;

   logic              push;
   logic              pop;
   logic [DATA_W-1:0] rd_val_p0;

   // Priority: hardwired zero, then the write landing this cycle, then the array.
   function automatic logic [DATA_W-1:0] read_word(
      input logic [4:0]          sel,
      input logic [32*DATA_W-1:0] flat,
      input logic                we,
      input logic [4:0]          ws,
      input logic [DATA_W-1:0]   wd
   );
      logic [DATA_W-1:0] w;
      if (ZERO_REG0 && (sel == 5'd0))
         w = '0;
      else if (BYPASS && we && (ws == sel))
         w = wd;
      else
         w = flat[int'(sel)*DATA_W +: DATA_W];
      return w;
   endfunction

   assign rd.req_ready = !rst && (count_q != 2'd2);
   assign rd.rsp_valid = (count_q != 2'd0);
   assign rd.rsp_data  = (count_q != 2'd0) ? entry_q[rd_ptr_q] : '0;

   assign push = rd.req_valid && rd.req_ready;
   assign pop  = rd.rsp_valid && rd.rsp_ready;

   assign rd_val_p0 = read_word(rd.req_sel, in_flat, wr_en, wr_sel, wr_data);

   // Capture stage: the selected word is frozen into the FIFO at accept time.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         entry_q[0] <= '0;
         entry_q[1] <= '0;
      end else begin
         if (push) begin
            entry_q[wr_ptr_q] <= rd_val_p0;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_mux32_1_rd.sv
// Directed bench for mux32_1_rd: reset, index sweep, bypass, backpressure,
// steady push/pop and mid-transfer reset.
module tb_mux32_1_rd;

   localparam int DATA_W = 32;

   logic                   clk;
   logic                   rst;
   logic [32*DATA_W-1:0]   in_flat;
   logic                   wr_en;
   logic [4:0]             wr_sel;
   logic [DATA_W-1:0]      wr_data;

   int checks;
   int passed;

   mux32_1_rd_if #(.DATA_W(DATA_W)) rd  ();
   mux32_1_rd_if #(.DATA_W(DATA_W)) rd2 ();

   mux32_1_rd #(.DATA_W(DATA_W), .ZERO_REG0(1'b1), .BYPASS(1'b1)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_flat (in_flat),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_data (wr_data),
      .rd      (rd.slave)
   );

   // Second instance without bypass sees identical traffic.
   mux32_1_rd #(.DATA_W(DATA_W), .ZERO_REG0(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk     (clk),
      .rst     (rst),
      .in_flat (in_flat),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_data (wr_data),
      .rd      (rd2.slave)
   );

   assign rd2.req_valid = rd.req_valid;
   assign rd2.req_sel   = rd.req_sel;
   assign rd2.rsp_ready = rd.rsp_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_word(input int k, input logic [DATA_W-1:0] v);
      in_flat[k*DATA_W +: DATA_W] = v;
   endtask

   initial begin
      checks       = 0;
      passed       = 0;
      rst          = 1'b1;
      wr_en        = 1'b0;
      wr_sel       = 5'd0;
      wr_data      = '0;
      rd.req_valid = 1'b1;
      rd.req_sel   = 5'd1;
      rd.rsp_ready = 1'b0;
      for (int k = 0; k < 32; k++) set_word(k, 32'hA000_0000 + k);

      // Reset held with a request pending.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_req_ready", {31'd0, rd.req_ready}, 32'd0);
         chk("rst_rsp_valid", {31'd0, rd.rsp_valid}, 32'd0);
         chk("rst_rsp_data", rd.rsp_data, 32'd0);
      end
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, rd.req_ready}, 32'd1);
      tick();
      chk("first_rsp_valid", {31'd0, rd.rsp_valid}, 32'd1);
      chk("first_rsp_data", rd.rsp_data, 32'hA000_0001);
      rd.req_valid = 1'b0;
      rd.rsp_ready = 1'b1;
      tick();
      chk("first_drained", {31'd0, rd.rsp_valid}, 32'd0);

      // Back-to-back sweep; occupancy sits at one entry with push and pop together.
      rd.req_valid = 1'b1;
      for (int s = 0; s < 32; s++) begin
         rd.req_sel = 5'(s);
         tick();
         chk("sweep_valid", {31'd0, rd.rsp_valid}, 32'd1);
         chk("sweep_data", rd.rsp_data, (s == 0) ? 32'd0 : 32'hA000_0000 + s);
         chk("sweep_ready", {31'd0, rd.req_ready}, 32'd1);
      end
      rd.req_valid = 1'b0;
      tick();
      chk("sweep_drained", {31'd0, rd.rsp_valid}, 32'd0);

      // Bypass: same-index write is forwarded, other index is not.
      set_word(5, 32'h1111_1111);
      wr_en        = 1'b1;
      wr_sel       = 5'd5;
      wr_data      = 32'h2222_2222;
      rd.req_sel   = 5'd5;
      rd.req_valid = 1'b1;
      tick();
      rd.req_valid = 1'b0;
      wr_en        = 1'b0;
      chk("bypass_hit", rd.rsp_data, 32'h2222_2222);
      chk("nobypass_hit", rd2.rsp_data, 32'h1111_1111);
      tick();
      wr_en        = 1'b1;
      wr_sel       = 5'd6;
      rd.req_valid = 1'b1;
      tick();
      rd.req_valid = 1'b0;
      wr_en        = 1'b0;
      chk("bypass_miss", rd.rsp_data, 32'h1111_1111);
      chk("nobypass_miss", rd2.rsp_data, 32'h1111_1111);
      tick();
      wr_en        = 1'b1;
      wr_sel       = 5'd0;
      rd.req_sel   = 5'd0;
      rd.req_valid = 1'b1;
      tick();
      rd.req_valid = 1'b0;
      wr_en        = 1'b0;
      chk("zero_beats_bypass", rd.rsp_data, 32'd0);
      tick();

      // Backpressure: two fit, the third is held.
      rd.rsp_ready = 1'b0;
      rd.req_valid = 1'b1;
      rd.req_sel   = 5'd3;
      chk("bp_ready0", {31'd0, rd.req_ready}, 32'd1);
      tick();
      rd.req_sel = 5'd4;
      chk("bp_ready1", {31'd0, rd.req_ready}, 32'd1);
      tick();
      rd.req_sel = 5'd7;
      chk("bp_full", {31'd0, rd.req_ready}, 32'd0);
      set_word(3, 32'hDEAD_0003);
      set_word(4, 32'hDEAD_0004);
      tick();
      chk("bp_still_full", {31'd0, rd.req_ready}, 32'd0);
      chk("bp_head3", rd.rsp_data, 32'hA000_0003);
      rd.rsp_ready = 1'b1;
      tick();
      chk("bp_head4", rd.rsp_data, 32'hA000_0004);
      chk("bp_room", {31'd0, rd.req_ready}, 32'd1);
      tick();
      rd.req_valid = 1'b0;
      set_word(7, 32'hDEAD_0007);
      #1;
      chk("bp_head7", rd.rsp_data, 32'hA000_0007);
      tick();
      chk("bp_drained", {31'd0, rd.rsp_valid}, 32'd0);

      // Reset while full discards both entries.
      rd.rsp_ready = 1'b0;
      rd.req_valid = 1'b1;
      rd.req_sel   = 5'd1;
      tick();
      rd.req_sel = 5'd2;
      tick();
      chk("mid_full_valid", {31'd0, rd.rsp_valid}, 32'd1);
      chk("mid_full_ready", {31'd0, rd.req_ready}, 32'd0);
      rst          = 1'b1;
      rd.req_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, rd.rsp_valid}, 32'd0);
      chk("mid_rst_data", rd.rsp_data, 32'd0);
      chk("mid_rst_ready", {31'd0, rd.req_ready}, 32'd1);
      rd.req_sel = 5'bxxxxx;
      tick();
      chk("idle_no_push", {31'd0, rd.rsp_valid}, 32'd0);
      rd.req_sel   = 5'd9;
      rd.req_valid = 1'b1;
      tick();
      rd.req_valid = 1'b0;
      chk("after_rst_data", rd.rsp_data, 32'hA000_0009);
      rd.rsp_ready = 1'b1;
      tick();
      chk("after_rst_single", {31'd0, rd.rsp_valid}, 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
